// File: rtl/mesi_isc_broad_snoop_cntl_pkg.sv
// Shared constants for the broadcast snoop controller: cbus commands,
// broadcast entry types and the controller state encoding.
package mesi_isc_pkg;

   localparam int CBUS_CMD_NOP      = 0;
   localparam int CBUS_CMD_WR_SNOOP = 1;
   localparam int CBUS_CMD_RD_SNOOP = 2;
   localparam int CBUS_CMD_EN_WR    = 3;
   localparam int CBUS_CMD_EN_RD    = 4;

   localparam int BROAD_TYPE_NOP    = 0;
   localparam int BROAD_TYPE_WR     = 1;
   localparam int BROAD_TYPE_RD     = 2;

   typedef enum logic [1:0] {
      IDLE,
      SNOOP,
      GRANT,
      POP
   } state_t;

endpackage

// File: rtl/mesi_isc_broad_snoop_cntl_if.sv
// Broadcast FIFO head / cbus bundle between the snoop controller (master)
// and its FIFO + CPU environment (slave).
interface mesi_isc_broad_snoop_cntl_if #(
   parameter int CBUS_CMD_WIDTH   = 3,
   parameter int ADDR_WIDTH       = 32,
   parameter int BROAD_TYPE_WIDTH = 2,
   parameter int BROAD_ID_WIDTH   = 7
);

   logic                        broad_fifo_status_empty_i;
   logic [ADDR_WIDTH-1:0]       broad_addr_i;
   logic [BROAD_TYPE_WIDTH-1:0] broad_type_i;
   logic [1:0]                  broad_cpu_id_i;
   logic [BROAD_ID_WIDTH-1:0]   broad_id_i;
   logic [3:0]                  cbus_ack_array_i;
   logic                        broad_fifo_rd_o;
   logic [4*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o;
   logic [ADDR_WIDTH-1:0]       cbus_addr_o;
   logic [BROAD_ID_WIDTH-1:0]   cbus_id_o;
   logic                        busy_o;

   modport master (
      input  broad_fifo_status_empty_i, broad_addr_i, broad_type_i,
             broad_cpu_id_i, broad_id_i, cbus_ack_array_i,
      output broad_fifo_rd_o, cbus_cmd_array_o, cbus_addr_o, cbus_id_o, busy_o
   );

   modport slave (
      output broad_fifo_status_empty_i, broad_addr_i, broad_type_i,
             broad_cpu_id_i, broad_id_i, cbus_ack_array_i,
      input  broad_fifo_rd_o, cbus_cmd_array_o, cbus_addr_o, cbus_id_o, busy_o
   );

endinterface

// File: rtl/mesi_isc_broad_snoop_cntl.sv
// Broadcast FIFO consumer: snoops the three non-originating CPUs, grants the
// originator once all have acked, then pops the entry. One broadcast in flight.
module mesi_isc_broad_snoop_cntl
   import mesi_isc_pkg::*;
#(
   parameter int CBUS_CMD_WIDTH   = 3,
   parameter int ADDR_WIDTH       = 32,
   parameter int BROAD_TYPE_WIDTH = 2,
   parameter int BROAD_ID_WIDTH   = 7
) (
   input  logic                        clk,
   input  logic                        rst,
   mesi_isc_broad_snoop_cntl_if.master bus
);

   localparam logic [CBUS_CMD_WIDTH-1:0]   C_NOP   = CBUS_CMD_WIDTH'(CBUS_CMD_NOP);
   localparam logic [CBUS_CMD_WIDTH-1:0]   C_WR_SN = CBUS_CMD_WIDTH'(CBUS_CMD_WR_SNOOP);
   localparam logic [CBUS_CMD_WIDTH-1:0]   C_RD_SN = CBUS_CMD_WIDTH'(CBUS_CMD_RD_SNOOP);
   localparam logic [CBUS_CMD_WIDTH-1:0]   C_EN_WR = CBUS_CMD_WIDTH'(CBUS_CMD_EN_WR);
   localparam logic [CBUS_CMD_WIDTH-1:0]   C_EN_RD = CBUS_CMD_WIDTH'(CBUS_CMD_EN_RD);
   localparam logic [BROAD_TYPE_WIDTH-1:0] T_WR    = BROAD_TYPE_WIDTH'(BROAD_TYPE_WR);
   localparam logic [BROAD_TYPE_WIDTH-1:0] T_RD    = BROAD_TYPE_WIDTH'(BROAD_TYPE_RD);

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [ADDR_WIDTH-1:0]       r_addr;
   logic [BROAD_TYPE_WIDTH-1:0] r_type;
   logic [1:0]                  r_cpu;
   logic [BROAD_ID_WIDTH-1:0]   r_id;
   logic [1:0]                  r_cool;
   logic                        r_rd;
   logic                        r_busy;
   logic [3:0]                  w_done;
   logic [3:0]                  w_orig_mask;
   logic                        w_head_bcast;
   logic                        w_head_drop;
   logic                        w_snoop_done;

   assign w_head_bcast = !bus.broad_fifo_status_empty_i &&
                         (bus.broad_type_i == T_WR || bus.broad_type_i == T_RD);
   // NOP/illegal entries are held off until 4 cycles after the previous pop
   assign w_head_drop  = !bus.broad_fifo_status_empty_i && !w_head_bcast && (r_cool == '0);
   assign w_orig_mask  = 4'b0001 << r_cpu;
   assign w_snoop_done = ((w_done | w_orig_mask) == 4'hF);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_head_bcast) w_state_nxt = SNOOP;
                  else if (w_head_drop) w_state_nxt = POP;
         SNOOP:   if (w_snoop_done) w_state_nxt = GRANT;
         GRANT:   if (bus.cbus_ack_array_i[r_cpu]) w_state_nxt = POP;
         POP:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_rd    <= 1'b0;
         r_busy  <= 1'b0;
         r_cool  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rd    <= (w_state_nxt == POP);
         r_busy  <= (w_state_nxt != IDLE);
         if (r_state == POP)   r_cool <= 2'd2;
         else if (r_cool != '0) r_cool <= r_cool - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr <= '0;
         r_type <= '0;
         r_cpu  <= '0;
         r_id   <= '0;
      end else if (r_state == IDLE && w_head_bcast) begin
         r_addr <= bus.broad_addr_i;
         r_type <= bus.broad_type_i;
         r_cpu  <= bus.broad_cpu_id_i;
         r_id   <= bus.broad_id_i;
      end
   end

   for (genvar n = 0; n < 4; n++) begin : g_slice
      logic [CBUS_CMD_WIDTH-1:0] r_cmd;
      logic                      r_done;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_cmd  <= '0;
            r_done <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_head_bcast)
                     r_cmd <= (bus.broad_cpu_id_i == 2'(n)) ? C_NOP :
                              (bus.broad_type_i == T_WR)     ? C_WR_SN : C_RD_SN;
               end
               SNOOP: begin
                  if (r_cmd != C_NOP && bus.cbus_ack_array_i[n]) begin
                     r_cmd  <= C_NOP;
                     r_done <= 1'b1;
                  end else if (w_snoop_done && r_cpu == 2'(n)) begin
                     r_cmd <= (r_type == T_WR) ? C_EN_WR : C_EN_RD;
                  end
               end
               GRANT: begin
                  if (r_cmd != C_NOP && bus.cbus_ack_array_i[n]) begin
                     r_cmd  <= C_NOP;
                     r_done <= 1'b1;
                  end
               end
               default: begin
                  r_cmd  <= C_NOP;
                  r_done <= 1'b0;
               end
            endcase
         end
      end

      assign w_done[n] = r_done;
      assign bus.cbus_cmd_array_o[n*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = r_cmd;
   end

   assign bus.broad_fifo_rd_o = r_rd;
   assign bus.busy_o          = r_busy;
   assign bus.cbus_addr_o     = r_addr;
   assign bus.cbus_id_o       = r_id;

endmodule

// File: tb/tb_mesi_isc_broad_snoop_cntl.sv
// Directed + randomized bench for the broadcast snoop controller, with a
// FIFO/CPU environment and a transaction-rule reference model.
module tb_mesi_isc_broad_snoop_cntl;
   import mesi_isc_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  typ;
      logic [1:0]  cpu;
      logic [6:0]  id;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mesi_isc_broad_snoop_cntl_if #(
      .CBUS_CMD_WIDTH(3), .ADDR_WIDTH(32), .BROAD_TYPE_WIDTH(2), .BROAD_ID_WIDTH(7)
   ) bus ();

   mesi_isc_broad_snoop_cntl #(
      .CBUS_CMD_WIDTH(3), .ADDR_WIDTH(32), .BROAD_TYPE_WIDTH(2), .BROAD_ID_WIDTH(7)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   ent_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   pops_exp  = 0;
   int   pops_seen = 0;
   logic rd_seen = 1'b0;

   // reference model: phase 0 idle, 1 snoop, 2 grant, 3 pop
   int   m_st;
   int   m_cmd[4];
   ent_t m_e;
   int   m_pop_cyc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic drive_head();
      if (q.size() > 0) begin
         bus.broad_fifo_status_empty_i = 1'b0;
         bus.broad_addr_i   = q[0].addr;
         bus.broad_type_i   = q[0].typ;
         bus.broad_cpu_id_i = q[0].cpu;
         bus.broad_id_i     = q[0].id;
      end else begin
         bus.broad_fifo_status_empty_i = 1'b1;
         bus.broad_addr_i   = $urandom;
         bus.broad_type_i   = 2'($urandom_range(1, 2));
         bus.broad_cpu_id_i = 2'($urandom);
         bus.broad_id_i     = 7'($urandom);
      end
   endtask

   task automatic model_reset();
      m_st = 0;
      for (int n = 0; n < 4; n++) m_cmd[n] = 0;
      m_e = '{addr: '0, typ: '0, cpu: '0, id: '0};
      m_pop_cyc = -100;
   endtask

   task automatic model_edge();
      logic       e;
      logic [1:0] t;
      logic [3:0] a;
      bit         pending;
      e = bus.broad_fifo_status_empty_i;
      t = bus.broad_type_i;
      a = bus.cbus_ack_array_i;
      case (m_st)
         0: begin
            if (!e && (t == 1 || t == 2)) begin
               m_e = '{addr: bus.broad_addr_i, typ: t, cpu: bus.broad_cpu_id_i, id: bus.broad_id_i};
               for (int n = 0; n < 4; n++)
                  m_cmd[n] = (n == int'(m_e.cpu)) ? 0 : ((t == 1) ? 1 : 2);
               m_st = 1;
            end else if (!e && (cyc - m_pop_cyc >= 4)) begin
               m_st = 3; m_pop_cyc = cyc; pops_exp++;
            end
         end
         1: begin
            pending = 0;
            for (int n = 0; n < 4; n++) if (m_cmd[n] != 0) pending = 1;
            if (!pending) begin
               m_cmd[m_e.cpu] = (m_e.typ == 1) ? 3 : 4;
               m_st = 2;
            end else begin
               for (int n = 0; n < 4; n++) if (m_cmd[n] != 0 && a[n]) m_cmd[n] = 0;
            end
         end
         2: begin
            if (a[m_e.cpu]) begin
               m_cmd[m_e.cpu] = 0; m_st = 3; m_pop_cyc = cyc; pops_exp++;
            end
         end
         default: m_st = 0;
      endcase
   endtask

   task automatic check_outputs();
      logic [3:0] live;
      for (int n = 0; n < 4; n++) begin
         chk($sformatf("cmd%0d", n), 64'(bus.cbus_cmd_array_o[n*3 +: 3]), 64'(m_cmd[n]));
         live[n] = (bus.cbus_cmd_array_o[n*3 +: 3] != 3'd0);
      end
      chk("rd",   64'(bus.broad_fifo_rd_o), 64'(m_st == 3));
      chk("busy", 64'(bus.busy_o),          64'(m_st != 0));
      chk("addr", 64'(bus.cbus_addr_o),     64'(m_e.addr));
      chk("id",   64'(bus.cbus_id_o),       64'(m_e.id));
      chk("rd_while_empty", 64'(bus.broad_fifo_rd_o & (q.size() == 0)), 64'(0));
      if (m_st == 2) chk("grant_onehot0", 64'($onehot0(live)), 64'(1));
   endtask

   task automatic step(input logic [3:0] a);
      bus.cbus_ack_array_i = a;
      @(posedge clk);
      cyc++;
      model_edge();
      if (rd_seen) begin
         if (q.size() > 0) void'(q.pop_front());
         pops_seen++;
      end
      #1;
      check_outputs();
      rd_seen = bus.broad_fifo_rd_o;
      drive_head();
   endtask

   task automatic push(input logic [1:0] t, input logic [1:0] c, input logic [31:0] ad,
                       input logic [6:0] id);
      q.push_back('{addr: ad, typ: t, cpu: c, id: id});
      drive_head();
   endtask

   task automatic drain(input int budget, input int pct);
      int g = 0;
      logic [3:0] a;
      while ((q.size() > 0 || m_st != 0) && g < budget) begin
         for (int n = 0; n < 4; n++) a[n] = ($urandom_range(0, 99) < pct);
         step(a);
         g++;
      end
      chk("drain_budget", 64'(q.size() + m_st), 64'(0));
   endtask

   task automatic hard_reset();
      #2 rst = 1'b1;
      #1;
      model_reset();
      q.delete();
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;
      rd_seen = 1'b0;
      drive_head();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cbus_ack_array_i = '0;
      drive_head();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;

      // read broadcast from CPU1, acks one at a time in order 0,2,3
      push(2'd2, 2'd1, 32'h1000, 7'd5);
      step(4'b0000);
      chk("rd_snoop_cmd0", 64'(bus.cbus_cmd_array_o[2:0]), 64'(2));
      step(4'b0001);
      step(4'b0100);
      step(4'b1000);
      step(4'b0000);
      chk("rd_grant_cmd1", 64'(bus.cbus_cmd_array_o[5:3]), 64'(4));
      step(4'b0010);
      chk("rd_pop", 64'(bus.broad_fifo_rd_o), 64'(1));
      chk("rd_id", 64'(bus.cbus_id_o), 64'(5));
      step(4'b0000);
      step(4'b0000);

      // write broadcast from CPU3, all snoop acks in first snoop cycle
      push(2'd1, 2'd3, 32'hABCD_0040, 7'd77);
      step(4'b0000);
      step(4'b0111);
      step(4'b0000);
      chk("wr_grant_cmd3", 64'(bus.cbus_cmd_array_o[11:9]), 64'(3));
      step(4'b1000);
      step(4'b0000);
      step(4'b0000);

      // stalled CPU0 ack with spurious originator (CPU2) acks meanwhile
      push(2'd2, 2'd2, $urandom, 7'($urandom));
      step(4'b0000);
      step(4'b1010);
      for (int i = 0; i < 20; i++) step(4'($urandom) & 4'b1110);
      chk("stall_cmd0", 64'(bus.cbus_cmd_array_o[2:0]), 64'(2));
      chk("stall_busy", 64'(bus.busy_o), 64'(1));
      step(4'b0001);
      drain(200, 50);

      // NOP entries: immediate pop, then spacing of 4 between pops
      repeat (3) step(4'b0000);
      push(2'd0, 2'($urandom), $urandom, 7'($urandom));
      push(2'd0, 2'($urandom), $urandom, 7'($urandom));
      step(4'b0000);
      chk("nop_pop", 64'(bus.broad_fifo_rd_o), 64'(1));
      for (int i = 0; i < 8; i++) step(4'($urandom));

      // back-to-back broadcasts
      push(2'd1, 2'd0, $urandom, 7'($urandom));
      push(2'd2, 2'd2, $urandom, 7'($urandom));
      drain(400, 40);

      // reset mid-SNOOP
      push(2'd2, 2'd0, $urandom, 7'($urandom));
      step(4'b0000);
      step(4'b0000);
      hard_reset();
      chk("rst_cmds", 64'(bus.cbus_cmd_array_o), 64'(0));

      // randomized traffic
      for (int i = 0; i < 40; i++)
         push(2'($urandom_range(0, 2)), 2'($urandom), $urandom, 7'($urandom));
      drain(6000, 35);
      repeat (4) step(4'($urandom));

      chk("pop_count", 64'(pops_seen), 64'(pops_exp));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
